// File: rtl/apb_uart_ctrl.sv
// apb_uart_ctrl: APB3 slave UART with TX/RX FIFOs, 16x-oversampling baud
// generator, LSB-first framing (start, DATA_BITS data, one stop), sticky
// overrun/frame error flags and a registered, maskable level interrupt.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge), synchronous active-low reset
//   PSEL, PENABLE,       APB3 slave request; PADDR[3:2] selects DATA, STATUS,
//   PWRITE, PADDR,       DIV or CTRL; upper address bits must be zero
//   PWDATA
//   PRDATA, PREADY,      read data (access phase only, else 0), ready (tied 1),
//   PSLVERR              error response (access phase only)
//   rxd                  asynchronous serial input
//   txd                  serial output, idles high
//   irq                  level interrupt, one cycle behind its cause
//   tx_state_dbg,        current TX / RX FSM state (IDLE=0 START=1 DATA=2 STOP=3)
//   rx_state_dbg
module apb_uart_ctrl #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 32,
   parameter int DIV_W      = 16,
   parameter int DEF_DIV    = 54
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic              rxd,
   output logic              txd,
   output logic              irq,
   output logic [1:0]        tx_state_dbg,
   output logic [1:0]        rx_state_dbg
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} uart_state_t;

   // APB handshake: PSEL&PENABLE is the request (valid) and PREADY is tied
   // high, so every access completes in its access phase; all register side
   // effects commit on the rising edge that ends that phase.
   logic access, addr_ok, sel_data, apb_err, wr_ok, rd_ok;
   logic tx_push, rx_pop, div_wr, ctrl_wr, stat_wr;

   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0]          tx_wr, tx_rd, rx_wr, rx_rd;
   logic                 tx_full, tx_empty, rx_full, rx_empty;

   logic [DIV_W-1:0] div_q, baud_cnt;
   logic             tick;
   logic [4:0]       ctrl_q;   // [0]tx_en [1]rx_en [2]ie_rx [3]ie_tx [4]ie_err
   logic             ovr_q, ferr_q;

   uart_state_t          tx_state, tx_next;
   logic                 tx_pop, tx_bit_done;
   logic [3:0]           tx_tcnt;
   logic [BW-1:0]        tx_bidx;
   logic [DATA_BITS-1:0] tx_shreg;

   uart_state_t          rx_state, rx_next;
   logic                 rx_s1, rx_s2, rx_s3, rx_fall;
   logic                 rx_mid, rx_bit_done, rx_sample, rx_push, ovr_set, ferr_set;
   logic [3:0]           rx_rcnt;
   logic [BW-1:0]        rx_bidx;
   logic [DATA_BITS-1:0] rx_shreg;

   logic unused_bits;
   assign unused_bits = ^{PADDR[1:0], PWDATA};

   // ---------------- APB decode ----------------
   assign access   = PSEL & PENABLE;
   assign addr_ok  = (PADDR[ADDR_W-1:4] == '0);
   assign sel_data = (PADDR[3:2] == 2'd0);
   // Full/empty here are the registered values, i.e. before any FSM push/pop
   // happening in the same cycle.
   assign apb_err  = access & (~addr_ok | (sel_data & PWRITE & tx_full)
                                        | (sel_data & ~PWRITE & rx_empty));
   assign wr_ok    = access & PWRITE & ~apb_err;
   assign rd_ok    = access & ~PWRITE & ~apb_err;
   assign tx_push  = wr_ok & sel_data;
   assign rx_pop   = rd_ok & sel_data;
   assign stat_wr  = wr_ok & (PADDR[3:2] == 2'd1);
   assign div_wr   = wr_ok & (PADDR[3:2] == 2'd2);
   assign ctrl_wr  = wr_ok & (PADDR[3:2] == 2'd3);
   assign PREADY   = 1'b1;
   assign PSLVERR  = apb_err;

   always_comb begin
      PRDATA = '0;
      if (rd_ok) begin
         case (PADDR[3:2])
            2'd0: PRDATA = 32'(rx_mem[rx_rd[AW-1:0]]);
            2'd1: PRDATA = {26'd0, ferr_q, ovr_q, rx_empty, rx_full, tx_empty, tx_full};
            2'd2: PRDATA = 32'(div_q);
            2'd3: PRDATA = {27'd0, ctrl_q};
         endcase
      end
   end

   // ---------------- FIFOs (wrap-bit pointers) ----------------
   assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
   assign tx_empty = (tx_wr == tx_rd);
   assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
   assign rx_empty = (rx_wr == rx_rd);

   always_ff @(posedge PCLK) begin
      if (tx_push) tx_mem[tx_wr[AW-1:0]] <= PWDATA[DATA_BITS-1:0];
      if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_shreg;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tx_wr <= '0;
         tx_rd <= '0;
         rx_wr <= '0;
         rx_rd <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + (AW+1)'(1);
         if (tx_pop)  tx_rd <= tx_rd + (AW+1)'(1);
         if (rx_push) rx_wr <= rx_wr + (AW+1)'(1);
         if (rx_pop)  rx_rd <= rx_rd + (AW+1)'(1);
      end
   end

   // ---------------- registers, baud generator, flags, irq ----------------
   assign tick = (baud_cnt == div_q);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         div_q    <= DIV_W'(DEF_DIV);
         ctrl_q   <= 5'b00011;
         baud_cnt <= '0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (div_wr)  div_q  <= PWDATA[DIV_W-1:0];
         if (ctrl_wr) ctrl_q <= PWDATA[4:0];
         // A DIV write restarts the bit timing from a clean phase.
         if (div_wr || tick) baud_cnt <= '0;
         else                baud_cnt <= baud_cnt + DIV_W'(1);
         // A hardware set in the same cycle as a software clear wins.
         ovr_q  <= ovr_set  | (ovr_q  & ~(stat_wr & PWDATA[4]));
         ferr_q <= ferr_set | (ferr_q & ~(stat_wr & PWDATA[5]));
         irq    <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty)
                 | (ctrl_q[4] & (ovr_q | ferr_q));
      end
   end

   // ---------------- TX FSM ----------------
   always_comb begin
      tx_next     = tx_state;
      tx_pop      = 1'b0;
      tx_bit_done = tick && (tx_tcnt == 4'd15);
      txd         = 1'b1;
      case (tx_state)
         ST_IDLE: if (ctrl_q[0] && !tx_empty) begin
            tx_next = ST_START;
            tx_pop  = 1'b1;
         end
         ST_START: begin
            txd = 1'b0;
            if (tx_bit_done) tx_next = ST_DATA;
         end
         ST_DATA: begin
            txd = tx_shreg[tx_bidx];
            if (tx_bit_done && tx_bidx == BW'(DATA_BITS-1)) tx_next = ST_STOP;
         end
         ST_STOP: if (tx_bit_done) begin
            // Chain straight into the next frame when more data is queued.
            if (ctrl_q[0] && !tx_empty) begin
               tx_next = ST_START;
               tx_pop  = 1'b1;
            end else begin
               tx_next = ST_IDLE;
            end
         end
         default: tx_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tx_state <= ST_IDLE;
         tx_tcnt  <= '0;
         tx_bidx  <= '0;
         tx_shreg <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_pop) tx_shreg <= tx_mem[tx_rd[AW-1:0]];
         if (tx_state == ST_IDLE) tx_tcnt <= '0;
         else if (tick)           tx_tcnt <= tx_tcnt + 4'd1;
         if (tx_state != ST_DATA) tx_bidx <= '0;
         else if (tx_bit_done)    tx_bidx <= tx_bidx + BW'(1);
      end
   end

   // ---------------- RX FSM ----------------
   assign rx_fall = rx_s3 & ~rx_s2;

   always_comb begin
      rx_next     = rx_state;
      rx_sample   = 1'b0;
      rx_push     = 1'b0;
      ovr_set     = 1'b0;
      ferr_set    = 1'b0;
      rx_mid      = tick && (rx_rcnt == 4'd7);
      rx_bit_done = tick && (rx_rcnt == 4'd15);
      if (!ctrl_q[1]) begin
         rx_next = ST_IDLE;
      end else begin
         case (rx_state)
            ST_IDLE:  if (rx_fall) rx_next = ST_START;
            // Half a bit in: a line back high means the edge was a glitch.
            ST_START: if (rx_mid) rx_next = rx_s2 ? ST_IDLE : ST_DATA;
            ST_DATA:  if (rx_bit_done) begin
               rx_sample = 1'b1;
               if (rx_bidx == BW'(DATA_BITS-1)) rx_next = ST_STOP;
            end
            ST_STOP:  if (rx_bit_done) begin
               rx_next = ST_IDLE;
               if (!rx_s2)       ferr_set = 1'b1;
               else if (rx_full) ovr_set  = 1'b1;
               else              rx_push  = 1'b1;
            end
            default:  rx_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         rx_state <= ST_IDLE;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_rcnt  <= '0;
         rx_bidx  <= '0;
         rx_shreg <= '0;
      end else begin
         rx_state <= rx_next;
         rx_s1    <= rxd;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         // Restart the tick count at the mid-start point so later samples
         // land on bit centres.
         if (rx_state == ST_IDLE || (rx_state == ST_START && rx_next != ST_START))
            rx_rcnt <= '0;
         else if (tick)
            rx_rcnt <= rx_rcnt + 4'd1;
         if (rx_state != ST_DATA) rx_bidx <= '0;
         else if (rx_sample)      rx_bidx <= rx_bidx + BW'(1);
         if (rx_sample) rx_shreg[rx_bidx] <= rx_s2;
      end
   end

   assign tx_state_dbg = tx_state;
   assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Self-checking bench for apb_uart_ctrl: APB driver tasks, a serial-line
// decoder on txd, a serial-line driver on rxd (or txd looped back), and
// queue-based models of the FIFOs and sticky flags.
module tb_apb_uart_ctrl;

   localparam int DEPTH  = 16;
   localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_DIV = 32'h8, A_CTRL = 32'hC;

   logic        PCLK = 1'b0, PRESETn = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = '0, PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR, txd, irq, rxd;
   logic [1:0]  tx_dbg, rx_dbg;
   logic        rxd_drv = 1'b1, loop_en = 1'b0;

   int n_checks = 0, n_fail = 0;
   int bit_cyc = 16 * 55;

   logic [7:0] exp_q[$];      // bytes expected on the line / in loopback
   logic [7:0] tx_seen[$];    // bytes decoded from txd
   logic [7:0] rx_model[$];   // model of the RX FIFO contents
   logic       m_ovr = 1'b0, m_ferr = 1'b0;

   assign rxd = loop_en ? txd : rxd_drv;

   apb_uart_ctrl dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .rxd(rxd), .txd(txd), .irq(irq), .tx_state_dbg(tx_dbg), .rx_state_dbg(rx_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 PCLK = ~PCLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input logic tx_full_e, input logic tx_empty_e);
      return {26'd0, m_ferr, m_ovr, (rx_model.size() == 0), (rx_model.size() == DEPTH),
              tx_empty_e, tx_full_e};
   endfunction

   // ---------------- APB drivers ----------------
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; #2;
      err = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; #2;
      data = PRDATA; err = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic e;
      apb_write(addr, data, e);
   endtask

   task automatic check_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d; logic e;
      apb_read(addr, d, e);
      check(tag, d, exp);
   endtask

   // Drive one frame onto rxd_drv: start, 8 data LSB first, stop, one idle bit.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      @(posedge PCLK);
      for (int i = 0; i < 11; i++) begin
         #1 rxd_drv = (i < 10) ? bits[i] : 1'b1;
         repeat (bit_cyc) @(posedge PCLK);
      end
   endtask

   // Record txd for a whole frame and compare each bit cell cycle by cycle.
   task automatic check_tx_wave(input logic [7:0] b);
      logic w[640];
      int   t, s, bad, idx;
      logic e;
      t = 0;
      while (txd !== 1'b0 && t < 2000) begin
         @(negedge PCLK); t++;
      end
      check("wave_start_seen", {31'd0, txd}, 32'd0);
      for (int i = 0; i < 640; i++) begin
         w[i] = txd;
         @(negedge PCLK);
      end
      s = 0;
      while (s < 640 && w[s] == 1'b0) s++;
      check("wave_start_len", (s >= 61 && s <= 64) ? 32'd1 : 32'd0, 32'd1);
      for (int k = 0; k < 9; k++) begin
         e = (k < 8) ? b[k] : 1'b1;
         bad = 0;
         for (int c = 0; c < 64; c++) begin
            idx = s + 64 * k + c;
            if (idx < 640 && w[idx] !== e) bad++;
         end
         check($sformatf("wave_bit%0d_bad_cycles", k), bad, 0);
      end
   endtask

   // ---------------- txd line decoder ----------------
   initial begin : tx_monitor
      logic [7:0] b;
      forever begin
         @(negedge PCLK);
         if (PRESETn && txd === 1'b0) begin
            repeat (bit_cyc / 2) @(negedge PCLK);
            for (int i = 0; i < 8; i++) begin
               repeat (bit_cyc) @(negedge PCLK);
               b[i] = txd;
            end
            repeat (bit_cyc) @(negedge PCLK);
            tx_seen.push_back(b);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic        e;
      logic [7:0]  v;
      int          n, dv;

      // 1: reset state
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      @(negedge PCLK);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_prdata_idle", PRDATA, 32'd0);
      check("rst_pslverr_idle", {31'd0, PSLVERR}, 32'd0);
      check("rst_pready", {31'd0, PREADY}, 32'd1);
      check("rst_tx_state", {30'd0, tx_dbg}, 32'd0);
      check("rst_rx_state", {30'd0, rx_dbg}, 32'd0);
      check_rd("rst_status", A_STAT, 32'h0A);
      check_rd("rst_div", A_DIV, 32'd54);
      check_rd("rst_ctrl", A_CTRL, 32'h3);
      apb_read(A_DATA, d, e);
      check("rd_empty_err", {31'd0, e}, 32'd1);
      check("rd_empty_data", d, 32'd0);
      apb_read(32'h10, d, e);
      check("bad_addr_err", {31'd0, e}, 32'd1);
      apb_write(32'h8000_0008, 32'd7, e);
      check("bad_addr_wr_err", {31'd0, e}, 32'd1);
      check_rd("bad_addr_no_effect", A_DIV, 32'd54);

      // 2: single frame waveform at DIV=3
      wr(A_DIV, 32'd3);
      bit_cyc = 64;
      check_rd("div_readback", A_DIV, 32'd3);
      tx_seen.delete();
      wr(A_DATA, 32'hA5);
      check_tx_wave(8'hA5);
      check_rd("t2_status_after", A_STAT, 32'h0A);
      check("t2_frames", tx_seen.size(), 1);
      if (tx_seen.size() > 0) check("t2_decoded", {24'd0, tx_seen[0]}, 32'hA5);

      // 3: loopback of three bytes, then an empty read
      loop_en = 1'b1;
      exp_q = '{8'h00, 8'hFF, 8'h3C};
      foreach (exp_q[i]) wr(A_DATA, {24'd0, exp_q[i]});
      repeat (2400) @(negedge PCLK);
      while (exp_q.size() > 0) begin
         v = exp_q.pop_front();
         apb_read(A_DATA, d, e);
         check("t3_loop_data", d, {24'd0, v});
         check("t3_loop_err", {31'd0, e}, 32'd0);
      end
      apb_read(A_DATA, d, e);
      check("t3_4th_err", {31'd0, e}, 32'd1);
      check("t3_4th_data", d, 32'd0);
      loop_en = 1'b0;

      // 4: fill TX FIFO with tx disabled, overflow once, then release
      wr(A_DIV, 32'd0);
      bit_cyc = 16;
      wr(A_CTRL, 32'h2);
      exp_q.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         v = 8'($urandom);
         apb_write(A_DATA, {24'd0, v}, e);
         if (i < DEPTH) exp_q.push_back(v);
      end
      check("t4_overflow_err", {31'd0, e}, 32'd1);
      check_rd("t4_status_full", A_STAT, 32'h09);
      tx_seen.delete();
      wr(A_CTRL, 32'h3);
      repeat (DEPTH * 10 * 16 + 200) @(negedge PCLK);
      check("t4_frames", tx_seen.size(), DEPTH);
      for (int i = 0; i < DEPTH; i++)
         if (i < tx_seen.size()) check($sformatf("t4_byte%0d", i), {24'd0, tx_seen[i]}, {24'd0, exp_q[i]});
      check_rd("t4_status_done", A_STAT, 32'h0A);

      // 5: RX overrun with 17 frames, irq from ie_err, clear by STATUS write
      wr(A_DIV, 32'd1);
      bit_cyc = 32;
      rx_model.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         v = 8'($urandom);
         send_frame(v, 1'b1);
         if (rx_model.size() < DEPTH) rx_model.push_back(v);
         else m_ovr = 1'b1;
      end
      repeat (bit_cyc) @(negedge PCLK);
      check_rd("t5_status_ovr", A_STAT, exp_status(1'b0, 1'b1));
      check("t5_irq_masked", {31'd0, irq}, 32'd0);
      wr(A_CTRL, 32'h13);
      repeat (3) @(negedge PCLK);
      check("t5_irq_set", {31'd0, irq}, 32'd1);
      wr(A_STAT, 32'h10);
      m_ovr = 1'b0;
      repeat (3) @(negedge PCLK);
      check("t5_irq_clr", {31'd0, irq}, 32'd0);
      check_rd("t5_status_clr", A_STAT, exp_status(1'b0, 1'b1));
      while (rx_model.size() > 0) begin
         v = rx_model.pop_front();
         check_rd("t5_rx_byte", A_DATA, {24'd0, v});
      end
      check_rd("t5_status_drained", A_STAT, exp_status(1'b0, 1'b1));

      // 6: framing error, glitch rejection, then a good frame
      send_frame(8'h5A, 1'b0);
      m_ferr = 1'b1;
      check_rd("t6_status_ferr", A_STAT, exp_status(1'b0, 1'b1));
      check("t6_irq_ferr", {31'd0, irq}, 32'd1);
      wr(A_STAT, 32'h20);
      m_ferr = 1'b0;
      check_rd("t6_status_clr", A_STAT, exp_status(1'b0, 1'b1));
      @(posedge PCLK); #1 rxd_drv = 1'b0;
      repeat (3 * 2) @(posedge PCLK);
      #1 rxd_drv = 1'b1;
      repeat (20 * bit_cyc) @(negedge PCLK);
      check_rd("t6_glitch_nothing", A_STAT, exp_status(1'b0, 1'b1));
      send_frame(8'hC3, 1'b1);
      check_rd("t6_good_frame", A_DATA, 32'hC3);

      // 7: randomized loopback bursts at random divisors
      loop_en = 1'b1;
      for (int r = 0; r < 3; r++) begin
         dv = $urandom_range(0, 3);
         wr(A_DIV, dv);
         bit_cyc = 16 * (dv + 1);
         check_rd("t7_div", A_DIV, dv);
         n = $urandom_range(2, 6);
         exp_q.delete();
         for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            exp_q.push_back(v);
            wr(A_DATA, {24'd0, v});
         end
         repeat (n * 10 * bit_cyc + 4 * bit_cyc) @(negedge PCLK);
         while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check_rd("t7_loop_byte", A_DATA, {24'd0, v});
         end
         check_rd("t7_status", A_STAT, exp_status(1'b0, 1'b1));
      end
      loop_en = 1'b0;

      // 8: reset in the middle of a frame
      wr(A_DATA, 32'h00);
      repeat (3 * bit_cyc) @(negedge PCLK);
      check("t8_mid_frame_low", {31'd0, txd}, 32'd0);
      @(posedge PCLK); #1 PRESETn = 1'b0;
      @(posedge PCLK); #1 PRESETn = 1'b1;
      @(negedge PCLK);
      check("t8_txd_after_rst", {31'd0, txd}, 32'd1);
      check("t8_tx_state", {30'd0, tx_dbg}, 32'd0);
      check_rd("t8_status", A_STAT, 32'h0A);
      check_rd("t8_div", A_DIV, 32'd54);
      check_rd("t8_ctrl", A_CTRL, 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
